datapath_seq: RTL

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_pkg.sv | 15 +
 rtl/datapath_seq_regfile.sv | 35 +++
 rtl/datapath_seq.sv | 77 +++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared state encoding, opcodes and sizing for the sequential datapath controller.
package datapath_pkg;
  localparam int DP_WIDTH = 8;
  localparam int DP_NREGS = 8;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_LT    = 3'b101;
  localparam logic [2:0] OP_LOADI = 3'b111;
  function automatic logic op_legal(input logic [2:0] op);
    return op != 3'b100 && op != 3'b110;
  endfunction
endpackage

// File: rtl/datapath_seq_regfile.sv
// datapath_seq_regfile: register file with two operand read ports, a debug read port,
// one synchronous write port and r0 hardwired to zero.
module datapath_seq_regfile
  import datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int NREGS = DP_NREGS,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd2,
  input  logic [AW-1:0]    ra3,
  output logic [WIDTH-1:0] rd3
);
  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wa] = wd;
    mem_d[0] = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
  assign rd1 = ra1 == '0 ? '0 : mem_q[ra1];
  assign rd2 = ra2 == '0 ? '0 : mem_q[ra2];
  assign rd3 = ra3 == '0 ? '0 : mem_q[ra3];
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: four-state serial controller sequencing one instruction at a time
// through an external combinational ALU and a local register file.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int NREGS = DP_NREGS,
  parameter int WIDTH = DP_WIDTH,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [AW-1:0]    instr_rd,
  input  logic [AW-1:0]    instr_rs1,
  input  logic [AW-1:0]    instr_rs2,
  input  logic             instr_imm_en,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  output logic             done,
  output logic             err,
  output logic             flag_z,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);
  state_t state_q, state_d;
  logic [2:0] op_q, op_d, ctrl_q, ctrl_d;
  logic [AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic imm_en_q, imm_en_d, z_q, z_d, flag_z_q, flag_z_d;
  logic [WIDTH-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] rs1_data, rs2_data;
  logic legal, loadi;
  assign instr_ready = state_q == S_IDLE;
  assign legal = op_legal(op_q);
  assign loadi = op_q == OP_LOADI;
  assign done = state_q == S_WB && legal;
  assign err = state_q == S_WB && !legal;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_ctrl = ctrl_q;
  assign flag_z = flag_z_q;
  datapath_seq_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .we(done), .wa(rd_q), .wd(res_q),
    .ra1(rs1_q), .rd1(rs1_data),
    .ra2(rs2_q), .rd2(rs2_data),
    .ra3(dbg_sel), .rd3(dbg_data)
  );
  // Operand registers load in DECODE and clear on leaving WB so the ALU sees zeros in IDLE.
  always_comb begin
    state_d = instr_ready ? (instr_valid ? S_DECODE : S_IDLE) : state_t'(state_q + 2'd1);
    {op_d, rd_d, rs1_d, rs2_d, imm_en_d, imm_d} = instr_ready && instr_valid
      ? {instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm}
      : {op_q, rd_q, rs1_q, rs2_q, imm_en_q, imm_q};
    a_d = state_q == S_DECODE ? rs1_data : state_q == S_WB ? '0 : a_q;
    b_d = state_q == S_DECODE ? (imm_en_q ? imm_q : rs2_data) : state_q == S_WB ? '0 : b_q;
    ctrl_d = state_q == S_DECODE ? (legal && !loadi ? op_q : OP_ADD) : state_q == S_WB ? OP_ADD : ctrl_q;
    res_d = state_q == S_EXEC ? (loadi ? imm_q : alu_result) : res_q;
    z_d = state_q == S_EXEC ? (loadi ? imm_q == '0 : alu_z) : z_q;
    flag_z_d = done ? z_q : flag_z_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      {op_q, rd_q, rs1_q, rs2_q, imm_en_q, imm_q} <= '0;
      {a_q, b_q, ctrl_q, res_q, z_q, flag_z_q} <= '0;
    end else begin
      state_q <= state_d;
      {op_q, rd_q, rs1_q, rs2_q, imm_en_q, imm_q} <= {op_d, rd_d, rs1_d, rs2_d, imm_en_d, imm_d};
      {a_q, b_q, ctrl_q, res_q, z_q, flag_z_q} <= {a_d, b_d, ctrl_d, res_d, z_d, flag_z_d};
    end
endmodule
